// File: rtl/alu_reservation_station.sv
// ALU reservation-station bank: holds issued ops, snoops the CDB for
// pending operands and hands the lowest-index ready op to the ALU.
module alu_reservation_station #(
  parameter int NUM_ENTRIES = 4,
  parameter int TAG_W       = 4,
  parameter int TAG_BASE    = 1
) (
  input  logic                               CLK,
  input  logic                               RST_N,
  input  logic                               issue_valid,
  output logic                               issue_ready,
  input  logic [3:0]                         issue_alu_fun,
  input  logic [31:0]                        issue_v1,
  input  logic [TAG_W-1:0]                   issue_t1,
  input  logic [31:0]                        issue_v2,
  input  logic [TAG_W-1:0]                   issue_t2,
  output logic [TAG_W-1:0]                   issue_tag,
  input  logic                               cdb_valid,
  input  logic [TAG_W-1:0]                   cdb_tag,
  input  logic [31:0]                        cdb_val,
  output logic                               fu_valid,
  input  logic                               fu_ready,
  output logic [3:0]                         fu_alu_fun,
  output logic [31:0]                        fu_op1,
  output logic [31:0]                        fu_op2,
  output logic [TAG_W-1:0]                   fu_tag,
  output logic [$clog2(NUM_ENTRIES+1)-1:0]   occupancy
);

  localparam int IDX_W = (NUM_ENTRIES > 1) ? $clog2(NUM_ENTRIES) : 1;
  localparam int OCC_W = $clog2(NUM_ENTRIES + 1);

  logic [NUM_ENTRIES-1:0] r_busy;
  logic [3:0]             r_fun [NUM_ENTRIES];
  logic [31:0]            r_v1  [NUM_ENTRIES];
  logic [TAG_W-1:0]       r_q1  [NUM_ENTRIES];
  logic [31:0]            r_v2  [NUM_ENTRIES];
  logic [TAG_W-1:0]       r_q2  [NUM_ENTRIES];
  logic [OCC_W-1:0]       r_occ;

  logic [NUM_ENTRIES-1:0] w_rdy;
  logic [NUM_ENTRIES-1:0] w_alloc_oh;
  logic [NUM_ENTRIES-1:0] w_disp_oh;
  logic [IDX_W-1:0]       w_free_idx;
  logic [IDX_W-1:0]       w_disp_idx;
  logic                   w_acc;
  logic                   w_disp;
  logic                   w_cdb_hit;
  logic                   w_byp1;
  logic                   w_byp2;

  always_comb begin
    w_rdy      = '0;
    w_alloc_oh = '0;
    w_disp_oh  = '0;
    w_free_idx = '0;
    w_disp_idx = '0;
    // Scan high to low so the lowest index wins
    for (int i = NUM_ENTRIES - 1; i >= 0; i--) begin
      w_rdy[i] = r_busy[i] && (r_q1[i] == '0) && (r_q2[i] == '0);
      if (!r_busy[i]) begin
        w_free_idx = IDX_W'(i);
        w_alloc_oh = NUM_ENTRIES'(1) << i;
      end
      if (w_rdy[i]) begin
        w_disp_idx = IDX_W'(i);
        w_disp_oh  = NUM_ENTRIES'(1) << i;
      end
    end
  end

  assign issue_ready = ~&r_busy;
  assign issue_tag   = TAG_W'(TAG_BASE) + TAG_W'(w_free_idx);
  assign fu_valid    = |w_rdy;
  assign occupancy   = r_occ;

  always_comb begin
    fu_alu_fun = '0;
    fu_op1     = '0;
    fu_op2     = '0;
    fu_tag     = '0;
    if (fu_valid) begin
      fu_alu_fun = r_fun[w_disp_idx];
      fu_op1     = r_v1[w_disp_idx];
      fu_op2     = r_v2[w_disp_idx];
      fu_tag     = TAG_W'(TAG_BASE) + TAG_W'(w_disp_idx);
    end
  end

  assign w_acc     = issue_valid && issue_ready;
  assign w_disp    = fu_valid && fu_ready;
  assign w_cdb_hit = cdb_valid && (cdb_tag != '0);
  assign w_byp1    = w_cdb_hit && (issue_t1 == cdb_tag);
  assign w_byp2    = w_cdb_hit && (issue_t2 == cdb_tag);

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      r_busy <= '0;
      r_occ  <= '0;
      for (int i = 0; i < NUM_ENTRIES; i++) begin
        r_fun[i] <= '0;
        r_v1[i]  <= '0;
        r_q1[i]  <= '0;
        r_v2[i]  <= '0;
        r_q2[i]  <= '0;
      end
    end else begin
      for (int i = 0; i < NUM_ENTRIES; i++) begin
        if (w_cdb_hit && r_busy[i] && (r_q1[i] == cdb_tag)) begin
          r_v1[i] <= cdb_val;
          r_q1[i] <= '0;
        end
        if (w_cdb_hit && r_busy[i] && (r_q2[i] == cdb_tag)) begin
          r_v2[i] <= cdb_val;
          r_q2[i] <= '0;
        end
        if (w_disp && w_disp_oh[i]) r_busy[i] <= 1'b0;
        // The allocated entry is free, so it never collides with the above
        if (w_acc && w_alloc_oh[i]) begin
          r_busy[i] <= 1'b1;
          r_fun[i]  <= issue_alu_fun;
          r_v1[i]   <= w_byp1 ? cdb_val : issue_v1;
          r_q1[i]   <= w_byp1 ? '0 : issue_t1;
          r_v2[i]   <= w_byp2 ? cdb_val : issue_v2;
          r_q2[i]   <= w_byp2 ? '0 : issue_t2;
        end
      end
      r_occ <= r_occ + OCC_W'(w_acc) - OCC_W'(w_disp);
    end
  end

endmodule

// File: tb/tb_alu_reservation_station.sv
// Bench for alu_reservation_station: directed scenarios plus random
// traffic, with dispatches checked through a scoreboard queue.
module tb_alu_reservation_station;

  localparam int N  = 4;
  localparam int TW = 4;

  logic          CLK = 1'b0;
  logic          RST_N;
  logic          issue_valid;
  logic          issue_ready;
  logic [3:0]    issue_alu_fun;
  logic [31:0]   issue_v1;
  logic [TW-1:0] issue_t1;
  logic [31:0]   issue_v2;
  logic [TW-1:0] issue_t2;
  logic [TW-1:0] issue_tag;
  logic          cdb_valid;
  logic [TW-1:0] cdb_tag;
  logic [31:0]   cdb_val;
  logic          fu_valid;
  logic          fu_ready;
  logic [3:0]    fu_alu_fun;
  logic [31:0]   fu_op1;
  logic [31:0]   fu_op2;
  logic [TW-1:0] fu_tag;
  logic [2:0]    occupancy;

  alu_reservation_station #(.NUM_ENTRIES(N), .TAG_W(TW), .TAG_BASE(1)) dut (
    .CLK(CLK), .RST_N(RST_N),
    .issue_valid(issue_valid), .issue_ready(issue_ready),
    .issue_alu_fun(issue_alu_fun),
    .issue_v1(issue_v1), .issue_t1(issue_t1),
    .issue_v2(issue_v2), .issue_t2(issue_t2),
    .issue_tag(issue_tag),
    .cdb_valid(cdb_valid), .cdb_tag(cdb_tag), .cdb_val(cdb_val),
    .fu_valid(fu_valid), .fu_ready(fu_ready),
    .fu_alu_fun(fu_alu_fun), .fu_op1(fu_op1), .fu_op2(fu_op2),
    .fu_tag(fu_tag), .occupancy(occupancy)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    logic [3:0]  fun;
    logic [31:0] op1;
    logic [31:0] op2;
    int          tag;
  } disp_t;

  typedef struct {
    bit          busy;
    logic [3:0]  fun;
    logic [31:0] v1;
    int          q1;
    logic [31:0] v2;
    int          q2;
  } slot_t;

  disp_t sbq[$];
  slot_t slots[N];
  int    errs   = 0;
  int    checks = 0;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic void model_reset();
    for (int i = 0; i < N; i++) slots[i] = '{0, 0, 0, 0, 0, 0};
  endfunction

  // Drives one cycle of inputs, checks the visible state against the
  // model, queues the expected dispatch, then advances the model.
  task automatic step(input bit iv, input logic [3:0] fun,
                      input logic [31:0] v1, input int t1,
                      input logic [31:0] v2, input int t2,
                      input bit cv, input int ct, input logic [31:0] cval,
                      input bit fr);
    int f;
    int r;
    int cnt;
    bit hit;
    @(negedge CLK);
    issue_valid = iv; issue_alu_fun = fun;
    issue_v1 = v1; issue_t1 = TW'(t1);
    issue_v2 = v2; issue_t2 = TW'(t2);
    cdb_valid = cv; cdb_tag = TW'(ct); cdb_val = cval;
    fu_ready = fr;
    #1;
    f = -1; r = -1; cnt = 0;
    for (int i = 0; i < N; i++) begin
      if (slots[i].busy) cnt++;
      if (!slots[i].busy && f < 0) f = i;
      if (slots[i].busy && slots[i].q1 == 0 && slots[i].q2 == 0 && r < 0)
        r = i;
    end
    chk("issue_ready", issue_ready, f >= 0);
    chk("issue_tag", issue_tag, (f >= 0) ? f + 1 : 1);
    chk("occupancy", occupancy, cnt);
    chk("fu_valid", fu_valid, r >= 0);
    if (r >= 0 && fr)
      sbq.push_back('{slots[r].fun, slots[r].v1, slots[r].v2, r + 1});
    hit = cv && ct != 0;
    for (int i = 0; i < N; i++) begin
      if (slots[i].busy && hit && slots[i].q1 == ct) begin
        slots[i].v1 = cval; slots[i].q1 = 0;
      end
      if (slots[i].busy && hit && slots[i].q2 == ct) begin
        slots[i].v2 = cval; slots[i].q2 = 0;
      end
    end
    if (r >= 0 && fr) slots[r].busy = 0;
    if (iv && f >= 0) begin
      slots[f].busy = 1;
      slots[f].fun  = fun;
      slots[f].v1   = (hit && t1 == ct) ? cval : v1;
      slots[f].q1   = (hit && t1 == ct) ? 0 : t1;
      slots[f].v2   = (hit && t2 == ct) ? cval : v2;
      slots[f].q2   = (hit && t2 == ct) ? 0 : t2;
    end
  endtask

  task automatic idle(input bit fr);
    step(0, 0, 0, 0, 0, 0, 0, 0, 0, fr);
  endtask

  // Monitor: pops the expected dispatch whenever the DUT hands one over
  initial begin
    disp_t e;
    forever begin
      @(negedge CLK);
      #3;
      if (RST_N === 1'b1 && fu_valid && fu_ready) begin
        if (sbq.size() == 0) begin
          checks++; errs++;
          $display("FAIL unexpected_dispatch: got tag %0d expected none",
                   fu_tag);
        end else begin
          e = sbq.pop_front();
          chk("sb_fun", fu_alu_fun, e.fun);
          chk("sb_op1", fu_op1, e.op1);
          chk("sb_op2", fu_op2, e.op2);
          chk("sb_tag", fu_tag, e.tag);
        end
      end
    end
  end

  function automatic int rtag();
    int v = $urandom_range(0, 7);
    return (v < 2) ? 0 : v + 7;
  endfunction

  initial begin
    RST_N = 1'b0;
    issue_valid = 0; issue_alu_fun = 0; issue_v1 = 0; issue_t1 = 0;
    issue_v2 = 0; issue_t2 = 0; cdb_valid = 0; cdb_tag = 0; cdb_val = 0;
    fu_ready = 0;
    model_reset();
    #12;
    chk("rst_issue_ready", issue_ready, 1);
    chk("rst_issue_tag", issue_tag, 1);
    chk("rst_fu_valid", fu_valid, 0);
    chk("rst_occupancy", occupancy, 0);
    chk("rst_fu_op1", fu_op1, 0);
    chk("rst_fu_tag", fu_tag, 0);
    RST_N = 1'b1;

    // Ready issue
    step(1, 4'h0, 5, 0, 7, 0, 0, 0, 0, 0);
    idle(1);
    chk("ready_op1", fu_op1, 5);
    chk("ready_op2", fu_op2, 7);
    chk("ready_tag", fu_tag, 1);
    idle(0);
    chk("ready_occ", occupancy, 0);

    // CDB wakeup
    step(1, 4'h2, 0, 9, 3, 0, 0, 0, 0, 1);
    idle(1);
    step(0, 0, 0, 0, 0, 0, 1, 9, 32'hDEAD, 1);
    chk("wake_not_yet", fu_valid, 0);
    idle(1);
    chk("wake_op1", fu_op1, 32'hDEAD);
    chk("wake_op2", fu_op2, 3);

    // Issue/CDB bypass
    step(1, 4'h3, 1, 0, 0, 6, 1, 6, 42, 0);
    idle(1);
    chk("bypass_op2", fu_op2, 42);

    // Full, backpressure, wakeup of all four
    for (int i = 0; i < 4; i++) step(1, 4'(i), i, 12, 100 + i, 0, 0, 0, 0, 0);
    step(1, 4'hF, 77, 0, 77, 0, 0, 0, 0, 0);
    chk("full_ready", issue_ready, 0);
    chk("full_occ", occupancy, 4);
    step(0, 0, 0, 0, 0, 0, 1, 12, 32'hC0DE, 0);
    for (int i = 0; i < 4; i++) begin
      idle(1);
      chk("order_tag", fu_tag, i + 1);
    end
    idle(0);

    // Simultaneous dispatch and issue on a full station
    for (int i = 0; i < 4; i++) step(1, 4'h1, i, 0, i, 0, 0, 0, 0, 0);
    step(1, 4'h5, 55, 0, 66, 0, 0, 0, 0, 1);
    chk("simul_ready", issue_ready, 0);
    step(1, 4'h5, 55, 0, 66, 0, 0, 0, 0, 0);
    chk("simul_tag", issue_tag, 1);
    chk("simul_acc", issue_ready, 1);
    for (int i = 0; i < 5; i++) idle(1);

    // Reset mid-operation with three waiting entries
    for (int i = 0; i < 3; i++) step(1, 4'h7, i, 13, i, 0, 0, 0, 0, 0);
    @(negedge CLK);
    issue_valid = 0; fu_ready = 0; cdb_valid = 0;
    #2 RST_N = 1'b0;
    #1;
    chk("mid_rst_occ", occupancy, 0);
    chk("mid_rst_fu_valid", fu_valid, 0);
    chk("mid_rst_tag", issue_tag, 1);
    model_reset();
    #4 RST_N = 1'b1;

    // Random traffic
    for (int c = 0; c < 800; c++)
      step($urandom_range(0, 1), 4'($urandom), $urandom, rtag(),
           $urandom, rtag(), ($urandom_range(0, 9) < 4), rtag(),
           $urandom, ($urandom_range(0, 3) != 0));
    for (int c = 0; c < 24; c++)
      step(0, 0, 0, 0, 0, 0, 1, 9 + (c % 6), $urandom, 1);
    idle(0);
    chk("drain_occ", occupancy, 0);
    #5;
    chk("sb_empty", sbq.size(), 0);

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
